// File: rtl/beep_pkg.sv
// Shared types and constants for the beep sequencer.
// Holds the FSM state type, standard beep counts and default tick lengths.
package beep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ON,
      OFF,
      FIN
   } beep_state_t;

   localparam int BEEPS_ACK   = 1;
   localparam int BEEPS_WARN  = 2;
   localparam int BEEPS_FAULT = 3;

   // 100 ms at 50 MHz
   localparam int DEF_ON_TICKS  = 5_000_000;
   localparam int DEF_OFF_TICKS = 5_000_000;

endpackage

// File: rtl/beep_sequencer.sv
// Beep sequencer: emits N beeps of ON_TICKS high / OFF_TICKS low on buzzer_en.
// Ports: clk, reset (sync, active-high), start, beep_count[COUNT_W],
//   buzzer_en (to buzzer stage en), busy, done (1-cycle completion pulse),
//   abort (only when BEEP_SEQ_ABORT_EN is defined).
// Build option: define BEEP_SEQ_ABORT_EN to add the abort input.
module beep_sequencer
   import beep_pkg::*;
#(
   parameter int ON_TICKS  = DEF_ON_TICKS,
   parameter int OFF_TICKS = DEF_OFF_TICKS,
   parameter int COUNT_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] beep_count,
`ifdef BEEP_SEQ_ABORT_EN
   input  logic               abort,
`endif
   output logic               buzzer_en,
   output logic               busy,
   output logic               done
);

   localparam int MAX_T  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   // Keep at least one bit when both phases are a single cycle.
   localparam int TICK_W = ($clog2(MAX_T) < 1) ? 1 : $clog2(MAX_T);

   localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
   localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);

   beep_state_t        state_q, state_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [COUNT_W-1:0] rem_q, rem_d;
   logic               buzzer_q, busy_q, done_q;
   logic               abort_w;

`ifdef BEEP_SEQ_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      rem_d   = rem_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               tick_d = '0;
               if (beep_count != '0) begin
                  state_d = ON;
                  rem_d   = beep_count;
               end else begin
                  state_d = FIN;
               end
            end
         end
         ON: begin
            if (abort_w) begin
               state_d = FIN;
               tick_d  = '0;
               rem_d   = '0;
            end else if (tick_q == ON_LAST) begin
               state_d = OFF;
               tick_d  = '0;
               rem_d   = rem_q - COUNT_W'(1);
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         OFF: begin
            if (abort_w) begin
               state_d = FIN;
               tick_d  = '0;
               rem_d   = '0;
            end else if (tick_q == OFF_LAST) begin
               // Last beep still gets its OFF gap before finishing.
               state_d = (rem_q != '0) ? ON : FIN;
               tick_d  = '0;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up
   // with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         rem_q    <= '0;
         buzzer_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         rem_q    <= rem_d;
         buzzer_q <= (state_d == ON);
         busy_q   <= (state_d != IDLE);
         done_q   <= (state_d == FIN);
      end
   end

   assign buzzer_en = buzzer_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer (ON_TICKS=4, OFF_TICKS=3).
// Expected {buzzer_en,busy,done} per cycle are queued, then popped and compared.
module tb_beep_sequencer;

   localparam int ON_T  = 4;
   localparam int OFF_T = 3;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] beep_count = '0;
   logic          abort = 1'b0;
   logic          buzzer_en, busy, done;

   int total = 0;
   int bad   = 0;

   logic [2:0] expq[$];
   logic [2:0] exp_v;
   logic [2:0] obs;

   always #5 clk = ~clk;

   beep_sequencer #(
      .ON_TICKS (ON_T),
      .OFF_TICKS(OFF_T),
      .COUNT_W  (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .beep_count(beep_count),
`ifdef BEEP_SEQ_ABORT_EN
      .abort     (abort),
`endif
      .buzzer_en (buzzer_en),
      .busy      (busy),
      .done      (done)
   );

   assign obs = {buzzer_en, busy, done};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected trace for n beeps, starting the cycle after start is sampled.
   task automatic push_seq(input int n);
      for (int b = 0; b < n; b++) begin
         for (int i = 0; i < ON_T; i++) expq.push_back(3'b110);
         for (int i = 0; i < OFF_T; i++) expq.push_back(3'b010);
      end
      expq.push_back(3'b011);
      expq.push_back(3'b000);
      expq.push_back(3'b000);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (obs !== 3'b000) begin
            bad++;
            $display("FAIL reset_hold cyc%0d got=%b want=000", i, obs);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (obs !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle cyc%0d got=%b want=000", i, obs);
         end
      end
   endtask

   task automatic test_two_beeps();
      int i;
      start = 1'b1;
      beep_count = 4'd2;
      push_seq(2);
      step();
      start = 1'b0;
      beep_count = 4'd9;
      i = 0;
      while (expq.size() > 0) begin
         exp_v = expq.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL two_beeps cyc%0d got=%b want=%b", i, obs, exp_v);
         end
         i++;
         step();
      end
   endtask

   task automatic test_zero();
      int i;
      start = 1'b1;
      beep_count = 4'd0;
      push_seq(0);
      step();
      start = 1'b0;
      i = 0;
      while (expq.size() > 0) begin
         exp_v = expq.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL zero_beeps cyc%0d got=%b want=%b", i, obs, exp_v);
         end
         i++;
         step();
      end
   endtask

   task automatic test_repulse();
      int i;
      start = 1'b1;
      beep_count = 4'd1;
      push_seq(1);
      expq.push_back(3'b000);
      expq.push_back(3'b000);
      step();
      start = 1'b0;
      i = 0;
      while (expq.size() > 0) begin
         exp_v = expq.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL repulse cyc%0d got=%b want=%b", i, obs, exp_v);
         end
         // cycle 1 is in ON, cycle 7 is FIN
         start = (i == 1) || (i == ON_T + OFF_T);
         beep_count = 4'd1;
         i++;
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid();
      int i;
      int hit;
      start = 1'b1;
      beep_count = 4'd3;
      push_seq(3);
      step();
      start = 1'b0;
      hit = ON_T + OFF_T + 1;
      i = 0;
      while (i <= hit) begin
         exp_v = expq.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_mid cyc%0d got=%b want=%b", i, obs, exp_v);
         end
         i++;
         if (i > hit) reset = 1'b1;
         step();
      end
      reset = 1'b0;
      expq.delete();
      for (int k = 0; k < 4; k++) expq.push_back(3'b000);
      i = 0;
      while (expq.size() > 0) begin
         exp_v = expq.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_mid_after cyc%0d got=%b want=%b", i, obs, exp_v);
         end
         i++;
         step();
      end
      start = 1'b1;
      beep_count = 4'd1;
      push_seq(1);
      step();
      start = 1'b0;
      i = 0;
      while (expq.size() > 0) begin
         exp_v = expq.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_mid_restart cyc%0d got=%b want=%b", i, obs, exp_v);
         end
         i++;
         step();
      end
   endtask

   task automatic test_abort();
      int i;
      start = 1'b1;
      beep_count = 4'd3;
      expq.push_back(3'b110);
      expq.push_back(3'b110);
`ifdef BEEP_SEQ_ABORT_EN
      expq.push_back(3'b011);
      for (int k = 0; k < 3; k++) expq.push_back(3'b000);
`else
      push_seq(3);
      void'(expq.pop_front());
      void'(expq.pop_front());
`endif
      step();
      start = 1'b0;
      i = 0;
      while (expq.size() > 0) begin
         exp_v = expq.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL abort cyc%0d got=%b want=%b", i, obs, exp_v);
         end
         abort = (i == 1);
         i++;
         step();
      end
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_two_beeps();
      test_zero();
      test_repulse();
      test_reset_mid();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
